pchannel_power_ctrl: RTL

- Controller side of the P-Channel low-power interface (pstate/preq/paccept/pactive) for one PHY power domain.
- Sequences the four-phase pstate handshake for software commands.
- Auto-wakes the device on pactive and auto-sleeps it after a programmable idle period.
- Sits between the register/CSR layer and the device P-Channel port; all signals are synchronous to clk.

---
 rtl/pchannel_power_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pchannel_power_ctrl.sv
// rtl/pchannel_power_ctrl.sv - P-Channel controller with command, auto-wake and idle auto-sleep
module pchannel_power_ctrl #(
    parameter int IDLE_TIMEOUT = 256,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_state,
    output logic cmd_ready,
    input  logic auto_en,
    input  logic err_clr,
    output logic pstate,
    output logic preq,
    input  logic paccept,
    input  logic pactive,
    output logic cur_state,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_RELEASE
    } state_t;

    // A zero IDLE_TIMEOUT never qualifies the increment, so the expiry value is then irrelevant.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_LIMIT = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_n;
    logic             target;
    logic             target_n;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] ack_cnt;
    logic             idle_inc;
    logic             idle_expire;
    logic             same_state_cmd;
    logic             handshake_done;
    logic             ack_wait;
    logic             ack_hit;

    // pstate only follows cur_state in IDLE, so it is frozen for the whole REQ/RELEASE exchange.
    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign preq      = (state == ST_REQ);
    assign pstate    = (state == ST_IDLE) ? cur_state : target;
    assign ack_wait  = (state == ST_REQ) || (state == ST_RELEASE);
    assign ack_hit   = ack_wait && (ACK_TIMEOUT != 0) && (ack_cnt == ACK_LIMIT);

    // Next-state selection: command beats auto-wake beats idle expiry; handshake phases never abort.
    always_comb begin
        state_n        = state;
        target_n       = target;
        idle_inc       = 1'b0;
        idle_expire    = 1'b0;
        same_state_cmd = 1'b0;
        handshake_done = 1'b0;
        case (state)
            ST_IDLE: begin
                idle_inc    = cur_state && !pactive && auto_en && (IDLE_TIMEOUT != 0);
                idle_expire = idle_inc && (idle_cnt == IDLE_LAST);
                if (cmd_valid) begin
                    if (cmd_state != cur_state) begin
                        state_n  = ST_SETUP;
                        target_n = cmd_state;
                    end else begin
                        same_state_cmd = 1'b1;
                    end
                end else if (!cur_state && pactive && auto_en) begin
                    state_n  = ST_SETUP;
                    target_n = 1'b1;
                end else if (idle_expire) begin
                    state_n  = ST_SETUP;
                    target_n = 1'b0;
                end
            end
            ST_SETUP: begin
                state_n = ST_REQ;
            end
            ST_REQ: begin
                if (paccept) begin
                    state_n = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!paccept) begin
                    state_n        = ST_IDLE;
                    handshake_done = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state, handshake target and completion status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            target    <= 1'b0;
            cur_state <= 1'b0;
            done      <= 1'b0;
        end else begin
            state  <= state_n;
            target <= target_n;
            done   <= handshake_done || same_state_cmd;
            if (handshake_done) begin
                cur_state <= target;
            end
        end
    end

    // Sticky ack-timeout flag; a new timeout outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (ack_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

    // Idle counter: saturating count of quiet RUN cycles, cleared on activity, expiry or leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!idle_inc || idle_expire || (state_n != ST_IDLE)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Ack counter: restarts on every phase change, saturates while waiting for one paccept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= '0;
        end else if (state_n != state) begin
            ack_cnt <= '0;
        end else if (ack_wait && (ack_cnt != CNT_MAX)) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

endmodule
